// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side circular FIFO between the UART receiver and the bus slave.
// Captures a byte on each rx_done cycle and presents the oldest byte first-word-fall-through.
// Reports occupancy, status flags and a sticky overrun flag for dropped bytes.
module uart_rx_fifo #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned AFULL_LVL = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done,
    input  logic [DATA_W-1:0] r_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overrun,
    input  logic              ovr_clr
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              afull_q, afull_d;
    logic              overrun_q, overrun_d;

    logic              do_pop;
    logic              do_wr;
    logic              drop;

    // Accept/drop decisions and next-state for pointers, count, flags.
    // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
    always_comb begin
        do_pop    = 1'b0;
        do_wr     = 1'b0;
        drop      = 1'b0;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        do_pop = rd_en && !empty_q;
        do_wr  = rx_done && (!full_q || do_pop);
        drop   = rx_done && full_q && !do_pop;

        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        count_d = count_q + CNT_W'(do_wr) - CNT_W'(do_pop);

        // Set wins over clear when a drop coincides with ovr_clr.
        if (drop) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end

        empty_d = (count_d == CNT_W'(0));
        full_d  = (count_d == CNT_W'(DEPTH));
        afull_d = (count_d >= CNT_W'(AFULL_LVL));
    end

    // Control and status registers; asynchronously cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            afull_q   <= afull_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage array; contents are not reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= r_data;
        end
    end

    assign rd_data     = mem[rd_ptr_q];
    assign empty       = empty_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign count       = count_q;
    assign overrun     = overrun_q;

endmodule
